// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and defaults for the APB4 master bridge: FSM state
// encoding, the PPROT attribute type and default parameter values.
package apb4_pkg;

  localparam int DEF_ADDR_W      = 9;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_SLAVES  = 2;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Bridge sequencing: idle, one-cycle setup phase, access phase with waits.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // PPROT[0]=privileged, PPROT[1]=non-secure, PPROT[2]=instruction.
  typedef logic [2:0] pprot_t;

  // Number of PADDR MSBs needed to pick one of n slaves.
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/apb4_master_bridge_if.sv
// Bundle of the request, APB4 and response signals of the bridge.
// The master modport is the bridge's view; the slave modport is the
// view of whatever drives requests and models the APB slave.
interface apb4_master_bridge_if
  import apb4_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES
);

  // Request side
  logic                  transfer;
  logic                  req_ready;
  logic                  read_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  pprot_t                req_prot;

  // APB4 bus
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  pprot_t                PPROT;
  logic                  PREADY;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PSLVERR;

  // Response side
  logic                  rsp_done;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  modport master (
    input  transfer, read_write, req_addr, req_wdata, req_strb, req_prot,
    input  PREADY, PRDATA, PSLVERR,
    output req_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output rsp_done, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output transfer, read_write, req_addr, req_wdata, req_strb, req_prot,
    output PREADY, PRDATA, PSLVERR,
    input  req_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  rsp_done, rsp_rdata, rsp_err, rsp_timeout
  );

endinterface

// File: rtl/apb4_master_bridge_sel_decoder.sv
// Slave-select decoder: turns the PADDR MSB field into a one-hot PSEL
// vector, all zero while the bus is idle.
module apb4_sel_decoder
  import apb4_pkg::*;
#(
  parameter int  NUM_SLAVES = DEF_NUM_SLAVES,
  localparam int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [NUM_SLAVES-1:0] psel_o
);

  // One comparator per slave; only the addressed one goes high.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
    assign psel_o[gi] = en_i & (sel_i == SEL_W'(gi));
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 master bridge: accepts a simple valid/ready request, runs the
// APB4 setup/access sequence, and reports completion with a one-cycle
// rsp_done pulse. Back-to-back requests skip IDLE.
// Optional feature: define APB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYC wait states (rsp_err=1, rsp_timeout=1, rsp_rdata=0).
module apb4_master_bridge
  import apb4_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb4_master_bridge_if.master bus
);

  localparam int SEL_W  = sel_width(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e          state_q, state_d;

  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q,  strb_d;
  pprot_t              prot_q,  prot_d;

  logic                rsp_done_q,  rsp_done_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                req_ready;
  logic                accept;
  logic                complete;
  logic                timeout_hit;
  logic [NUM_SLAVES-1:0] psel;

  // Ready in IDLE, or in ACCESS on the completing cycle; held low in reset.
  always_comb begin
    req_ready = 1'b0;
    if (PRESETn) begin
      if (state_q == ST_IDLE) begin
        req_ready = 1'b1;
      end else if (state_q == ST_ACCESS) begin
        req_ready = bus.PREADY;
      end
    end
  end

  assign accept   = bus.transfer & req_ready;
  assign complete = (state_q == ST_ACCESS) & bus.PREADY;

  // Next-state logic: SETUP is always one cycle; ACCESS waits for PREADY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_d = accept ? ST_SETUP : ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; strobes are zeroed for reads.
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    if (accept) begin
      write_d = bus.read_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      strb_d  = bus.read_write ? bus.req_strb : '0;
      prot_d  = bus.req_prot;
    end
  end

  // Response: pulse done after completion or timeout; read data is held.
  always_comb begin
    rsp_done_d  = complete | timeout_hit;
    rsp_err_d   = (complete & bus.PSLVERR) | timeout_hit;
    rsp_rdata_d = rsp_rdata_q;
    if (complete && !write_q) begin
      rsp_rdata_d = bus.PRDATA;
    end else if (timeout_hit) begin
      rsp_rdata_d = '0;
    end
  end

  // State, command and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      rsp_done_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      prot_q      <= prot_d;
      rsp_done_q  <= rsp_done_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Count stalled ACCESS cycles; zero outside ACCESS so each SETUP starts fresh.
  always_comb begin
    timeout_hit = 1'b0;
    wait_cnt_d  = '0;
    if (state_q == ST_ACCESS && !bus.PREADY) begin
      if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    rsp_timeout_d = timeout_hit;
  end

  // Wait counter and timeout flag registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  // No wait-state limit: an access lasts until the slave raises PREADY.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign bus.rsp_timeout    = 1'b0;
`endif

  apb4_sel_decoder #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_sel_decoder (
    .sel_i  (addr_q[ADDR_W-1 -: SEL_W]),
    .en_i   (state_q != ST_IDLE),
    .psel_o (psel)
  );

  assign bus.req_ready = req_ready;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = (state_q == ST_ACCESS);
  assign bus.PWRITE    = write_q;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.PSTRB     = strb_q;
  assign bus.PPROT     = prot_q;
  assign bus.rsp_done  = rsp_done_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb4_master_bridge.md
APB4_MASTER_BRIDGE -- requirements
Module: apb4_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width; multiple of 8.
REQ-003 SHALL have parameter NUM_SLAVES, default 2, PSEL vector width, power of two >= 2; SEL_W = log2(NUM_SLAVES).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 16, wait-state limit; used only with APB_TIMEOUT_EN.
REQ-005 SHALL have ports; one clock, reset asynchronous and active-low:
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- transfer  in  1  request valid
- req_ready  out  1  request accepted this cycle when transfer=1
- read_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  byte strobes
- req_prot  in  3  protection attributes
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  access phase
- PWRITE, PADDR, PWDATA, PSTRB, PPROT  out  1/ADDR_W/DATA_W/DATA_W/8/3  APB4 command
- PREADY  in  1  slave ready
- PRDATA  in  DATA_W  read data
- PSLVERR  in  1  slave error
- rsp_done  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, held until next completion
- rsp_err  out  1  error flag, valid with rsp_done
- rsp_timeout  out  1  timeout flag, valid with rsp_done

Function
REQ-006 SHALL implement FSM IDLE, SETUP, ACCESS.
REQ-007 req_ready SHALL be 1 in IDLE and in ACCESS when PREADY=1; else 0.
REQ-008 Accept (transfer & req_ready) SHALL register all req_* fields and enter SETUP next cycle.
REQ-009 SETUP SHALL last exactly one cycle: selected PSEL bit 1, PENABLE 0, then ACCESS.
REQ-010 ACCESS SHALL hold PENABLE=1 and all command outputs stable until PREADY=1.
REQ-011 PSEL index SHALL be PADDR[ADDR_W-1 -: SEL_W]; all other PSEL bits 0.
REQ-012 PSTRB SHALL be forced to 0 on reads.
REQ-013 On PREADY=1 in ACCESS: next cycle rsp_done=1, rsp_err=PSLVERR, rsp_rdata=PRDATA if read (unchanged on write).
REQ-014 Zero-wait latency: accept at edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_done cycle N+3.
REQ-015 Completion with new transfer accepted SHALL go ACCESS->SETUP directly (back-to-back, no IDLE); otherwise ACCESS->IDLE with PSEL=0, PENABLE=0.
REQ-016 transfer in SETUP, or in ACCESS with PREADY=0, SHALL be ignored.

Reset
REQ-017 PRESETn=0 SHALL immediately force IDLE and all outputs 0 (req_ready=1 after release), including mid-transfer; no rsp_done for the aborted transfer.

Configuration
REQ-018 With macro APB_TIMEOUT_EN defined: counter counts ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYC SHALL drop PSEL/PENABLE, return to IDLE, pulse rsp_done with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-019 Without APB_TIMEOUT_EN: no counter, unlimited wait states, rsp_timeout tied 0.
REQ-020 Counter SHALL clear on every SETUP entry.

Structure
REQ-021 Package apb4_pkg SHALL hold FSM state enum, PPROT typedef, and default parameter constants.
REQ-022 Sub-module apb4_sel_decoder SHALL map PADDR to one-hot PSEL.

Verification
REQ-023 Write addr 0x105, wdata 0xA5, strb 1, PREADY tied 1 -> PSEL=2'b10, PWDATA 0xA5, rsp_done at N+3, rsp_err 0.
REQ-024 Read addr 0x010, PREADY low 3 ACCESS cycles, PRDATA 0x3C -> PSEL=2'b01, PSTRB 0, rsp_rdata 0x3C at done.
REQ-025 Two writes back-to-back with transfer held -> second SETUP immediately follows first ACCESS, PENABLE low exactly one cycle between.
REQ-026 Read with PSLVERR=1 at PREADY -> rsp_err 1, rsp_timeout 0.
REQ-027 APB_TIMEOUT_EN, PREADY stuck 0 -> done after 16 ACCESS cycles, rsp_err 1, rsp_timeout 1, rsp_rdata 0.
REQ-028 PRESETn asserted in ACCESS -> PSEL, PENABLE 0 same cycle; no rsp_done; fresh transfer after release completes normally.
